bus_scheduler: RTL and testbench

//  Control end of the shared 4-node single-wire bus. The bus datapath selects one

---
 rtl/bus_scheduler.sv | 135 +++++++++++++
 tb/tb_bus_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bus_scheduler.sv
// bus_scheduler
//   Control end of a shared 4-node single-wire bus. Arbitrates transfer
//   requests round-robin, drives the datapath sender/receiver selects for one
//   fixed-length frame, then releases the bus after a one-cycle turnaround.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   req       req[i]: node i wants to send; held until done[i]/abort[i]
//   dest      dest[2i+1:2i]: destination of node i, sampled at grant
//   sender    datapath input select (granted node)
//   receiver  datapath output select (captured destination)
//   grant     one-hot bus owner, 0 when idle
//   active    high for the FRAME_LEN bit cycles of a frame
//   bit_idx   index of the bit on the bus, 0 when idle
//   done      one-cycle pulse: frame of node i completed
//   abort     one-cycle pulse: frame of node i cut short by req[i] dropping
module bus_scheduler #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned LEN_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [7:0]       dest,
    output logic [1:0]       sender,
    output logic [1:0]       receiver,
    output logic [3:0]       grant,
    output logic             active,
    output logic [LEN_W-1:0] bit_idx,
    output logic [3:0]       done,
    output logic [3:0]       abort
);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    localparam logic [LEN_W-1:0] LAST_BIT = LEN_W'(FRAME_LEN - 1);

    state_t           state, state_nx;
    logic [1:0]       last, last_nx;
    logic [1:0]       sender_nx, receiver_nx;
    logic [3:0]       grant_nx, done_nx, abort_nx;
    logic             active_nx;
    logic [LEN_W-1:0] bit_idx_nx;
    logic [1:0]       pick, cand;
    logic             pick_vld;
    logic             end_frame;

    // Round-robin search starting one past the last winner; k=4 wraps back
    // to the last winner itself so a lone requester is never starved.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        last_nx     = last;
        sender_nx   = sender;
        receiver_nx = receiver;
        grant_nx    = grant;
        active_nx   = active;
        bit_idx_nx  = bit_idx;
        done_nx     = '0;
        abort_nx    = '0;
        end_frame   = 1'b0;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nx    = XFER;
                    sender_nx   = pick;
                    receiver_nx = dest[{pick, 1'b0} +: 2];
                    grant_nx    = 4'b0001 << pick;
                    active_nx   = 1'b1;
                    bit_idx_nx  = '0;
                    last_nx     = pick;
                end
            end
            XFER: begin
                // A dropped request wins over completion, even on the last bit.
                if (!req[sender]) begin
                    abort_nx  = grant;
                    end_frame = 1'b1;
                end else if (bit_idx == LAST_BIT) begin
                    done_nx   = grant;
                    end_frame = 1'b1;
                end else begin
                    bit_idx_nx = bit_idx + LEN_W'(1);
                end
                if (end_frame) begin
                    state_nx   = GAP;
                    grant_nx   = '0;
                    active_nx  = 1'b0;
                    bit_idx_nx = '0;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 2'd3;
            sender   <= '0;
            receiver <= '0;
            grant    <= '0;
            active   <= 1'b0;
            bit_idx  <= '0;
            done     <= '0;
            abort    <= '0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            sender   <= sender_nx;
            receiver <= receiver_nx;
            grant    <= grant_nx;
            active   <= active_nx;
            bit_idx  <= bit_idx_nx;
            done     <= done_nx;
            abort    <= abort_nx;
        end
    end

endmodule

// File: tb/tb_bus_scheduler.sv
module tb_bus_scheduler;

    localparam int unsigned FL = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, req1;
    logic [7:0] dest;

    logic [1:0] sender, receiver, sender1, receiver1;
    logic [3:0] grant, done, abort, grant1, done1, abort1;
    logic       active, active1;
    logic [3:0] bit_idx, bit_idx1;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    bus_scheduler #(.FRAME_LEN(FL), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dest(dest),
        .sender(sender), .receiver(receiver), .grant(grant), .active(active),
        .bit_idx(bit_idx), .done(done), .abort(abort)
    );

    bus_scheduler #(.FRAME_LEN(1), .LEN_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .dest(8'hE4),
        .sender(sender1), .receiver(receiver1), .grant(grant1), .active(active1),
        .bit_idx(bit_idx1), .done(done1), .abort(abort1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [7:0] dest;
        logic [3:0] grant;
        logic [1:0] snd;
        logic [1:0] rcv;
        logic       act;
        logic [3:0] bi;
        logic [3:0] dn;
        logic [3:0] ab;
    } vec_t;

    vec_t vec[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Waits for the next grant, then follows a full frame to its done pulse.
    task automatic do_frame(input int unsigned node, input logic [1:0] rcv,
                            input int unsigned exp_steps, input string tag);
        int unsigned steps = 0;
        do begin
            step();
            steps++;
        end while (grant == 4'h0 && steps < 20);
        chk({tag, " latency"}, steps, exp_steps);
        chk({tag, " grant"}, grant, 4'b0001 << node);
        chk({tag, " sender"}, sender, node[1:0]);
        chk({tag, " receiver"}, receiver, rcv);
        chk({tag, " active"}, active, 1'b1);
        chk({tag, " bit_idx0"}, bit_idx, 4'd0);
        for (int unsigned b = 1; b < FL; b++) begin
            step();
            chk($sformatf("%s bit_idx%0d", tag, b), bit_idx, b);
            chk($sformatf("%s active%0d", tag, b), active, 1'b1);
        end
        step();
        chk({tag, " done"}, done, 4'b0001 << node);
        chk({tag, " abort"}, abort, 4'h0);
        chk({tag, " end grant"}, grant, 4'h0);
        chk({tag, " end active"}, active, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'h0;
        req1  = 4'h0;
        dest  = 8'h00;

        // Single frame from node 0 to node 2, then a frame aborted at bit 3.
        vec[0] = '{1'b0, 4'h0, 8'h00, 4'h0, 2'd0, 2'd0, 1'b0, 4'd0, 4'h0, 4'h0};
        vec[1] = '{1'b1, 4'h1, 8'h02, 4'h1, 2'd0, 2'd2, 1'b1, 4'd0, 4'h0, 4'h0};
        for (int i = 2; i <= 8; i++)
            vec[i] = '{1'b1, 4'h1, 8'h00, 4'h1, 2'd0, 2'd2, 1'b1, 4'(i - 1), 4'h0, 4'h0};
        vec[9]  = '{1'b1, 4'h1, 8'h00, 4'h0, 2'd0, 2'd2, 1'b0, 4'd0, 4'h1, 4'h0};
        vec[10] = '{1'b1, 4'h0, 8'h00, 4'h0, 2'd0, 2'd2, 1'b0, 4'd0, 4'h0, 4'h0};
        vec[11] = '{1'b1, 4'h1, 8'h03, 4'h1, 2'd0, 2'd3, 1'b1, 4'd0, 4'h0, 4'h0};
        vec[12] = '{1'b1, 4'h1, 8'h00, 4'h1, 2'd0, 2'd3, 1'b1, 4'd1, 4'h0, 4'h0};
        vec[13] = '{1'b1, 4'h1, 8'h00, 4'h1, 2'd0, 2'd3, 1'b1, 4'd2, 4'h0, 4'h0};
        vec[14] = '{1'b1, 4'h1, 8'h00, 4'h1, 2'd0, 2'd3, 1'b1, 4'd3, 4'h0, 4'h0};
        vec[15] = '{1'b1, 4'h0, 8'h00, 4'h0, 2'd0, 2'd3, 1'b0, 4'd0, 4'h0, 4'h1};
        vec[16] = '{1'b1, 4'h0, 8'h00, 4'h0, 2'd0, 2'd3, 1'b0, 4'd0, 4'h0, 4'h0};

        for (int i = 0; i < 17; i++) begin
            rst_n = vec[i].rst_n;
            req   = vec[i].req;
            dest  = vec[i].dest;
            step();
            chk($sformatf("vec%0d grant", i), grant, vec[i].grant);
            chk($sformatf("vec%0d sender", i), sender, vec[i].snd);
            chk($sformatf("vec%0d receiver", i), receiver, vec[i].rcv);
            chk($sformatf("vec%0d active", i), active, vec[i].act);
            chk($sformatf("vec%0d bit_idx", i), bit_idx, vec[i].bi);
            chk($sformatf("vec%0d done", i), done, vec[i].dn);
            chk($sformatf("vec%0d abort", i), abort, vec[i].ab);
        end

        // All four nodes requesting: strict rotation, two idle cycles between frames.
        do_reset();
        req  = 4'b1111;
        dest = 8'b00_11_10_01;
        do_frame(0, 2'd1, 1, "rr n0");
        do_frame(1, 2'd2, 2, "rr n1");
        do_frame(2, 2'd3, 2, "rr n2");
        do_frame(3, 2'd0, 2, "rr n3");
        do_frame(0, 2'd1, 2, "rr n0b");

        // Lone requester re-granted back-to-back, then 2 and 0 alternate.
        req = 4'b0100;
        do_frame(2, 2'd3, 2, "solo a");
        do_frame(2, 2'd3, 2, "solo b");
        req = 4'b0101;
        do_frame(0, 2'd1, 2, "alt n0");
        do_frame(2, 2'd3, 2, "alt n2");
        do_frame(0, 2'd1, 2, "alt n0b");
        do_frame(2, 2'd3, 2, "alt n2b");

        // Reset in the middle of a frame: no pulse, node 0 priority restored.
        req = 4'h0;
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 6; i++) step();
        chk("midrst grant", grant, 4'b0010);
        chk("midrst bit_idx5", bit_idx, 4'd5);
        rst_n = 1'b0;
        step();
        chk("midrst grant0", grant, 4'h0);
        chk("midrst sender0", sender, 2'd0);
        chk("midrst receiver0", receiver, 2'd0);
        chk("midrst active0", active, 1'b0);
        chk("midrst bit_idx0", bit_idx, 4'd0);
        chk("midrst done0", done, 4'h0);
        chk("midrst abort0", abort, 4'h0);
        rst_n = 1'b1;
        req   = 4'b1001;
        do_frame(0, 2'd1, 1, "postrst n0");
        do_frame(3, 2'd0, 2, "postrst n3");
        req = 4'h0;

        // One-bit frames.
        req1 = 4'b0010;
        step();
        chk("fl1 grant", grant1, 4'b0010);
        chk("fl1 active", active1, 1'b1);
        chk("fl1 bit_idx", bit_idx1, 4'd0);
        chk("fl1 receiver", receiver1, 2'd1);
        step();
        chk("fl1 done", done1, 4'b0010);
        chk("fl1 abort", abort1, 4'h0);
        chk("fl1 active off", active1, 1'b0);
        chk("fl1 grant off", grant1, 4'h0);
        req1 = 4'h0;
        step();
        chk("fl1 done clear", done1, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
